zx_bus_responder: RTL
=====================

# zx_bus_responder

Bus-side responder for the Z80 core: decodes the CPU's MREQ/IORQ/RD/WR/M1 strobes and serves each cycle. It handles memory reads and writes through a synchronous memory port, reads and writes the ULA port 0xFE, answers interrupt-acknowledge cycles, and generates the frame interrupt that drives the CPU's INT_n. It sits between the CPU wrapper and the RAM/ROM, keyboard and border logic, and supplies the read data that the top level places on the tri-state data bus.

## Interface
Parameters:
- FRAME_LEN, 69888: clk cycles per video frame (interrupt period).
- INT_LEN, 32: clk cycles that int_n is held low per frame.
- IM2_VECTOR, 8'hFF: byte driven during interrupt acknowledge.

Ports:
- clk  in  1  system clock; same clock as the CPU.
- reset  in  1  synchronous, active-high reset.
- addr  in  16  CPU address bus.
- d_in  in  8  CPU data bus as seen by the responder.
- d_out  out  8  read data toward the CPU.
- d_oe  out  1  top-level tri-state enable for d_out.
- mreq_n, iorq_n, rd_n, wr_n, m1_n  in  1 each  CPU strobes, active-low.
- int_n  out  1  frame interrupt to the CPU, active-low.
- mem_addr  out  16  memory address.
- mem_we  out  1  one-cycle write strobe.
- mem_wdata  out  8  memory write data.
- mem_rdata  in  8  memory read data, valid 1 clk after mem_addr.
- kbd_row  out  8  keyboard row select (addr[15:8] during port read).
- kbd_col  in  5  keyboard columns, active-low.
- ear_in  in  1  tape input.
- border  out  3  border colour.
- ear_out, mic_out  out  1 each  port 0xFE bits 4 and 3.

## Operation
- Strobes are sampled on every rising clk edge. A cycle starts when a qualifying strobe combination is seen asserted in a cycle where the previous sample had it deasserted.
- FSM states: IDLE, MEM_RD, MEM_WR, IO_RD, IO_WR, INTA.
- IDLE transitions:
  - !mreq_n & !rd_n goes to MEM_RD.
  - !mreq_n & !wr_n goes to MEM_WR.
  - !iorq_n & !m1_n goes to INTA. This check takes priority over the other IORQ decodes.
  - !iorq_n & !rd_n goes to IO_RD.
  - !iorq_n & !wr_n goes to IO_WR.
- MEM_RD:
  - mem_addr = addr.
  - Next cycle: d_out = mem_rdata and d_oe = 1.
  - d_out stays latched until the strobe releases.
- MEM_WR:
  - Exactly one mem_we pulse, with mem_wdata = d_in sampled while wr_n is low.
  - No further pulse until the strobe releases.
- IO_WR with addr[0]=0:
  - border <= d_in[2:0]
  - mic_out <= d_in[3]
  - ear_out <= d_in[4]
  - Writes with addr[0]=1 are ignored.
- IO_RD:
  - addr[0]=0: kbd_row = addr[15:8]; d_out = {1, ear_in, 1, kbd_col}.
  - addr[0]=1: d_out = 8'hFF.
  - d_oe = 1 in both cases.
- INTA: d_out = IM2_VECTOR, d_oe = 1.
- Return to IDLE: every non-IDLE state returns to IDLE on the first sample where the active strobes are all deasserted. d_oe drops in that same cycle.
- Frame counter:
  - Counts 0..FRAME_LEN-1 and wraps to 0.
  - int_n = 0 while count < INT_LEN, otherwise 1.
  - Runs independently of the FSM.
- kbd_row = 8'hFF when not in IO_RD.

## Timing
Reset values:
- FSM state IDLE, frame counter 0.
- d_oe=0, d_out=0, mem_we=0, mem_addr=0, mem_wdata=0, kbd_row=8'hFF.
- border=0, ear_out=0, mic_out=0.
- int_n=0 (counter 0 is inside the pulse).

Latency:
- Memory read: d_oe high 2 clk after the strobe edge is sampled (1 clk address, 1 clk memory).
- IO/INTA read: d_oe high 1 clk after detection.
- Write: mem_we or port register updated 1 clk after detection.

Boundary conditions:
- Reset asserted mid-cycle: state returns to IDLE, d_oe=0 in the next cycle, and no mem_we is issued.
- Strobes already asserted when reset releases: treated as an already-served cycle, so no action until they deassert.
- rd_n and wr_n both low: read takes priority.
- Counter wraps from FRAME_LEN-1 to 0; int_n falls on the wrap edge.
- INT_LEN >= FRAME_LEN is illegal and must be flagged by a simulation assertion.

## Configuration
- ROM_WRITE_PROTECT_EN defined:
  - MEM_WR with addr[15:14]=2'b00 suppresses mem_we.
  - The FSM still runs through MEM_WR normally.
- Undefined: all 64 KB are writable.

## Test plan
- Reset: hold reset 3 clk, then release → all outputs at the reset values above, int_n=0, and int_n rises after INT_LEN clk.
- Memory read: addr=16'h8000, mreq_n=rd_n=0, mem_rdata=8'hA5 → d_oe=1 and d_out=8'hA5 two clk later; d_oe=0 one clk after the strobes release.
- Memory write: addr=16'h4000, d_in=8'h3C, wr_n held low 3 clk → exactly one mem_we pulse with mem_wdata=8'h3C. Repeat at addr=16'h0100: with ROM_WRITE_PROTECT_EN there is no pulse; without it there is one pulse.
- Port 0xFE:
  - Write 8'h15 to addr 16'h00FE → border=3'b101, mic_out=0, ear_out=1.
  - Read from 16'hFEFE with kbd_col=5'b11110, ear_in=0 → kbd_row=8'hFE, d_out=8'hBE.
- INTA: iorq_n=m1_n=0 → d_out=8'hFF (IM2_VECTOR), d_oe=1. An IORQ read at addr 16'h00FF gives d_out=8'hFF.
- Interrupt period and reset mid-cycle:
  - With FRAME_LEN=100, INT_LEN=4: int_n is low for exactly 4 of every 100 clk over 3 frames.
  - Reset asserted during MEM_RD → d_oe=0 in the next cycle.

Source files
------------

// File: rtl/zx_bus_responder.sv
// Z80 bus responder: serves memory, ULA port 0xFE and INTA cycles, and generates the frame interrupt.
// Optional build macro ROM_WRITE_PROTECT_EN blocks memory writes to 0x0000-0x3FFF.
module zx_bus_responder #(
    parameter int unsigned FRAME_LEN  = 69888,
    parameter int unsigned INT_LEN    = 32,
    parameter logic [7:0]  IM2_VECTOR = 8'hFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] addr,
    input  logic [7:0]  d_in,
    output logic [7:0]  d_out,
    output logic        d_oe,
    input  logic        mreq_n,
    input  logic        iorq_n,
    input  logic        rd_n,
    input  logic        wr_n,
    input  logic        m1_n,
    output logic        int_n,
    output logic [15:0] mem_addr,
    output logic        mem_we,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    output logic [7:0]  kbd_row,
    input  logic [4:0]  kbd_col,
    input  logic        ear_in,
    output logic [2:0]  border,
    output logic        ear_out,
    output logic        mic_out
);

`ifdef ROM_WRITE_PROTECT_EN
    localparam bit ROM_WP = 1'b1;
`else
    localparam bit ROM_WP = 1'b0;
`endif

    localparam int unsigned CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

    typedef enum logic [2:0] {
        IDLE,
        MEM_RD,
        MEM_WR,
        IO_RD,
        IO_WR,
        INTA
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             released;
    logic [1:0]       phase;
    logic [CNT_W-1:0] frame_cnt;

    logic mreq, iorq, rd, wr, m1;
    logic mreq_q, iorq_q, rd_q, wr_q, m1_q;

    assign mreq = ~mreq_n;
    assign iorq = ~iorq_n;
    assign rd   = ~rd_n;
    assign wr   = ~wr_n;
    assign m1   = ~m1_n;

    // Previous strobe sample keeps running through reset, so strobes held across
    // reset release look like an already-served cycle.
    always_ff @(posedge clk) begin
        {mreq_q, iorq_q, rd_q, wr_q, m1_q} <= {mreq, iorq, rd, wr, m1};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        released   = 1'b0;
        unique case (state)
            IDLE: begin
                if (mreq) begin
                    if (rd) begin
                        if (!(mreq_q && rd_q)) state_next = MEM_RD;
                    end else if (wr && !(mreq_q && wr_q)) begin
                        state_next = MEM_WR;
                    end
                end else if (iorq) begin
                    if (m1) begin
                        if (!(iorq_q && m1_q)) state_next = INTA;
                    end else if (rd) begin
                        if (!(iorq_q && rd_q)) state_next = IO_RD;
                    end else if (wr && !(iorq_q && wr_q)) begin
                        state_next = IO_WR;
                    end
                end
            end
            MEM_RD:  released = !mreq && !rd;
            MEM_WR:  released = !mreq && !wr;
            IO_RD:   released = !iorq && !rd;
            IO_WR:   released = !iorq && !wr;
            INTA:    released = !iorq && !m1;
            default: released = 1'b1;
        endcase
        if (released) state_next = IDLE;
    end

    // phase sequences the one-shot actions: MEM_RD waits one clk for the memory
    // before latching, writes fire only in phase 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            phase     <= '0;
            d_out     <= '0;
            d_oe      <= 1'b0;
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
            border    <= '0;
            ear_out   <= 1'b0;
            mic_out   <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            if (state == IDLE) begin
                phase <= '0;
                if (state_next == MEM_RD || state_next == MEM_WR) mem_addr <= addr;
            end else if (released) begin
                phase <= '0;
                d_oe  <= 1'b0;
            end else begin
                case (state)
                    MEM_RD: begin
                        if (phase == 2'd1) begin
                            d_out <= mem_rdata;
                            d_oe  <= 1'b1;
                        end
                        if (phase != 2'd2) phase <= phase + 2'd1;
                    end
                    MEM_WR: begin
                        if (phase == 2'd0) begin
                            mem_we    <= !(ROM_WP && mem_addr[15:14] == 2'b00);
                            mem_wdata <= d_in;
                            phase     <= 2'd1;
                        end
                    end
                    IO_RD: begin
                        d_out <= addr[0] ? 8'hFF : {1'b1, ear_in, 1'b1, kbd_col};
                        d_oe  <= 1'b1;
                    end
                    IO_WR: begin
                        if (phase == 2'd0) begin
                            if (!addr[0]) begin
                                border  <= d_in[2:0];
                                mic_out <= d_in[3];
                                ear_out <= d_in[4];
                            end
                            phase <= 2'd1;
                        end
                    end
                    INTA: begin
                        d_out <= IM2_VECTOR;
                        d_oe  <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign kbd_row = (state == IO_RD && !addr[0]) ? addr[15:8] : 8'hFF;

    always_ff @(posedge clk) begin
        if (reset || frame_cnt == CNT_W'(FRAME_LEN - 1)) begin
            frame_cnt <= '0;
        end else begin
            frame_cnt <= frame_cnt + CNT_W'(1);
        end
    end

    assign int_n = (32'(frame_cnt) >= INT_LEN);

    int_len_legal: assert property (@(posedge clk) INT_LEN < FRAME_LEN)
        else $error("zx_bus_responder: INT_LEN must be smaller than FRAME_LEN");

endmodule
